// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter that drives the select of a 2:1 mux, with break-before-make switching.
// Latency: 1 clk from the sampled req/data to out_data/out_valid.
// Backpressure: none. A requester holds the mux while it requests, up to MAX_HOLD cycles if the other side is waiting.
module mux_select_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic             control,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_A = 2'd1;
    localparam logic [1:0] GRANT_B = 2'd2;
    localparam logic [1:0] SWITCH  = 2'd3;

    localparam int            CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] hold_cnt;
    logic          last;        // 0 = A, 1 = B
    logic          next_owner;  // target of a pending SWITCH
    logic          owner;
    logic          req_own;
    logic          req_oth;
    logic          granted;
    logic          entering;

    assign owner    = (state == GRANT_B);
    assign req_own  = owner ? req_b : req_a;
    assign req_oth  = owner ? req_a : req_b;
    assign granted  = (state == GRANT_A) || (state == GRANT_B);
    assign entering = ((state == IDLE) || (state == SWITCH)) &&
                      ((state_nxt == GRANT_A) || (state_nxt == GRANT_B));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_a && req_b) begin
                    state_nxt = last ? GRANT_A : GRANT_B;
                end else if (req_a) begin
                    state_nxt = GRANT_A;
                end else if (req_b) begin
                    state_nxt = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!req_own) begin
                    state_nxt = req_oth ? SWITCH : IDLE;
                end else if (req_oth && (hold_cnt == HOLD_MAX)) begin
                    state_nxt = SWITCH;
                end
            end
            SWITCH:  state_nxt = next_owner ? GRANT_B : GRANT_A;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_a    <= 1'b0;
            grant_b    <= 1'b0;
            control    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            hold_cnt   <= '0;
            last       <= 1'b1;
            next_owner <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_a   <= (state_nxt == GRANT_A);
            grant_b   <= (state_nxt == GRANT_B);
            out_valid <= 1'b0;

            if (granted) begin
                // The final word of a grant still moves on the cycle we leave.
                if (req_own) begin
                    out_valid <= 1'b1;
                    out_data  <= owner ? data_b : data_a;
                end
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + CW'(1);
                end
            end

            // Mux select flips when the dead cycle starts, not when the new grant does.
            if (state_nxt == SWITCH) begin
                next_owner <= ~owner;
                control    <= ~owner;
            end

            if (entering) begin
                control  <= (state_nxt == GRANT_B);
                last     <= (state_nxt == GRANT_B);
                hold_cnt <= '0;
            end
        end
    end
endmodule
